// File: rtl/fft_shift_demap.sv
// fft_shift_demap: ping-pong buffered fftshift and guard-bin removal for 128-point FFT output
module fft_shift_demap #(
    parameter int WIDTH = 18,
    parameter int N_ACT = 72
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    input  logic                    di_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im,
    output logic                    do_en,
    output logic [6:0]              do_idx,
    output logic                    do_last
);
    localparam int H = N_ACT / 2;
    typedef enum logic {IDLE, READ} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mem [256];
    logic [2*WIDTH-1:0] rd_word_q;
    logic [6:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, do_idx_q, do_idx_d, rd_addr;
    logic [1:0]         full_q, full_d;
    logic               wb_q, wb_d, rb_q, rb_d, do_en_q, do_en_d, do_last_q, do_last_d;
    logic               wr_last, rd_go, rd_last;
    always_comb begin
        wr_last   = di_en && wr_cnt_q == 7'd127;
        // a read is issued in the same cycle the bank is seen full, saving a cycle of latency
        rd_go     = state_q == READ || full_q[rb_q];
        rd_last   = rd_go && rd_cnt_q == 7'(N_ACT - 1);
        rd_addr   = rd_cnt_q < 7'(H) ? rd_cnt_q + 7'(128 - H) : rd_cnt_q - 7'(H);
        wr_cnt_d  = di_en ? wr_cnt_q + 7'd1 : wr_cnt_q;
        wb_d      = wb_q ^ wr_last;
        rb_d      = rb_q ^ rd_last;
        full_d    = full_q;
        // release before fill so a write completing into the just-drained bank is kept
        if (rd_last) full_d[rb_q] = 1'b0;
        if (wr_last) full_d[wb_q] = 1'b1;
        rd_cnt_d  = rd_last ? 7'd0 : rd_go ? rd_cnt_q + 7'd1 : rd_cnt_q;
        state_d   = rd_go && !(rd_last && !full_d[~rb_q]) ? READ : IDLE;
        do_en_d   = rd_go;
        do_idx_d  = rd_go ? rd_cnt_q : 7'd0;
        do_last_d = rd_last;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= '0;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            do_en_q   <= 1'b0;
            do_idx_q  <= '0;
            do_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            do_en_q   <= do_en_d;
            do_idx_q  <= do_idx_d;
            do_last_q <= do_last_d;
        end
    end
    always_ff @(posedge clk) begin
        if (di_en) mem[{wb_q, wr_cnt_q}] <= {di_re, di_im};
        rd_word_q <= mem[{rb_q, rd_addr}];
    end
    assign do_en   = do_en_q;
    assign do_idx  = do_idx_q;
    assign do_last = do_last_q;
    assign do_re   = do_en_q ? rd_word_q[2*WIDTH-1:WIDTH] : '0;
    assign do_im   = do_en_q ? rd_word_q[WIDTH-1:0] : '0;
endmodule

// File: tb/tb_fft_shift_demap.sv
// tb_fft_shift_demap: scoreboard bench driving N_ACT=72, 128 and 2 instances from one input stream
module tb_fft_shift_demap;
    typedef struct {
        int re;
        int im;
        int idx;
        bit last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [17:0]  di_re = '0, di_im = '0;
    logic                di_en = 1'b0;
    logic signed [17:0]  o_re [3];
    logic signed [17:0]  o_im [3];
    logic [6:0]          o_idx [3];
    logic                o_en [3];
    logic                o_last [3];

    int nact [3] = '{72, 128, 2};
    exp_t sb [3][$];
    int gaps [3][$];
    int cap_re [3][128];
    int cap_im [3][128];
    int first_cyc [3];
    int last_cyc [3] = '{-1000, -1000, -1000};
    int nout [3] = '{0, 0, 0};
    int cyc = 0;
    int last_in_cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_shift_demap #(.WIDTH(18), .N_ACT(72)) u72 (.clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_en(di_en),
        .do_re(o_re[0]), .do_im(o_im[0]), .do_en(o_en[0]), .do_idx(o_idx[0]), .do_last(o_last[0]));
    fft_shift_demap #(.WIDTH(18), .N_ACT(128)) u128 (.clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_en(di_en),
        .do_re(o_re[1]), .do_im(o_im[1]), .do_en(o_en[1]), .do_idx(o_idx[1]), .do_last(o_last[1]));
    fft_shift_demap #(.WIDTH(18), .N_ACT(2)) u2 (.clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_en(di_en),
        .do_re(o_re[2]), .do_im(o_im[2]), .do_en(o_en[2]), .do_idx(o_idx[2]), .do_last(o_last[2]));

    // scoreboard monitor: every valid output is popped and compared, idle outputs must be zero
    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 3; u++) begin
                if (o_en[u]) begin
                    exp_t e;
                    if (o_idx[u] == 7'd0) begin
                        first_cyc[u] = cyc;
                        gaps[u].push_back(cyc - last_cyc[u] - 1);
                    end
                    cap_re[u][o_idx[u]] = int'(o_re[u]);
                    cap_im[u][o_idx[u]] = int'(o_im[u]);
                    nout[u]++;
                    if (o_last[u]) last_cyc[u] = cyc;
                    checks++;
                    if (sb[u].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output n_act=%0d idx=%0d re=%0d cyc=%0d", nact[u], o_idx[u], o_re[u], cyc);
                    end else begin
                        e = sb[u].pop_front();
                        if (int'(o_re[u]) !== e.re || int'(o_im[u]) !== e.im || int'(o_idx[u]) !== e.idx || o_last[u] !== e.last) begin
                            failures++;
                            $display("FAIL output n_act=%0d got re=%0d im=%0d idx=%0d last=%0d want re=%0d im=%0d idx=%0d last=%0d",
                                nact[u], o_re[u], o_im[u], o_idx[u], o_last[u], e.re, e.im, e.idx, e.last);
                        end
                    end
                end else begin
                    checks++;
                    if (o_re[u] !== '0 || o_im[u] !== '0 || o_idx[u] !== '0 || o_last[u] !== 1'b0) begin
                        failures++;
                        $display("FAIL idle_zero n_act=%0d re=%0d im=%0d idx=%0d last=%0d want all 0", nact[u], o_re[u], o_im[u], o_idx[u], o_last[u]);
                    end
                end
            end
        end
    end

    task automatic push_sym(input int base);
        for (int u = 0; u < 3; u++) begin
            int h;
            h = nact[u] / 2;
            for (int i = 0; i < nact[u]; i++) begin
                int bin;
                bin = i < h ? 128 - h + i : i - h;
                sb[u].push_back('{re: base + bin, im: -(base + bin), idx: i, last: i == nact[u] - 1});
            end
        end
    endtask

    task automatic drive_sym(input int base, input int nbins, input bit gapped);
        for (int k = 0; k < nbins; k++) begin
            if (gapped) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                di_en = 1'b0;
            end
            @(posedge clk); #1;
            di_en = 1'b1;
            di_re = 18'(base + k);
            di_im = 18'(-(base + k));
            if (k == 127) begin
                last_in_cyc = cyc;
                push_sym(base);
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        di_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (sb[u].size() != 0) begin
                failures++;
                $display("FAIL %s_drain n_act=%0d pending=%0d want 0", name, nact[u], sb[u].size());
                sb[u].delete();
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (o_en[u] !== 1'b0 || o_re[u] !== '0 || o_im[u] !== '0 || o_idx[u] !== '0 || o_last[u] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs n_act=%0d en=%0d re=%0d im=%0d idx=%0d last=%0d want all 0",
                    nact[u], o_en[u], o_re[u], o_im[u], o_idx[u], o_last[u]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive_sym(0, 128, 1'b0);
        idle(200);
        check_val("basic_first_en_latency", first_cyc[0] - last_in_cyc, 2);
        check_val("basic_last_latency", last_cyc[0] - last_in_cyc, 73);
        check_val("basic_idx0_re", cap_re[0][0], 92);
        check_val("basic_idx0_im", cap_im[0][0], -92);
        check_val("basic_idx35_re", cap_re[0][35], 127);
        check_val("basic_idx36_re", cap_re[0][36], 0);
        check_val("basic_idx71_re", cap_re[0][71], 35);
        check_drained("basic");
    endtask

    task automatic test_mid_reset();
        int n0;
        drive_sym(500, 60, 1'b0);
        @(posedge clk); #1;
        di_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("midrst_en_zero", int'(o_en[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = nout[0];
        drive_sym(1000, 128, 1'b0);
        idle(200);
        check_val("midrst_count", nout[0] - n0, 72);
        check_val("midrst_idx0_re", cap_re[0][0], 1092);
        check_drained("midrst");
    endtask

    task automatic test_back_to_back();
        int want_gap [3] = '{56, 0, 126};
        for (int u = 0; u < 3; u++) gaps[u].delete();
        for (int s = 0; s < 4; s++) drive_sym(256 * s, 128, 1'b0);
        idle(300);
        for (int u = 0; u < 3; u++) begin
            check_val($sformatf("b2b_bursts_n%0d", nact[u]), gaps[u].size(), 4);
            for (int b = 1; b < 4 && b < gaps[u].size(); b++)
                check_val($sformatf("b2b_gap_n%0d_b%0d", nact[u], b), gaps[u][b], want_gap[u]);
        end
        check_val("b2b_n128_last_latency", last_cyc[1] - last_in_cyc, 129);
        check_drained("b2b");
    endtask

    task automatic test_gapped();
        drive_sym(0, 128, 1'b1);
        idle(200);
        check_val("gapped_first_en_latency", first_cyc[0] - last_in_cyc, 2);
        check_val("gapped_idx0_re", cap_re[0][0], 92);
        check_val("gapped_idx71_re", cap_re[0][71], 35);
        check_drained("gapped");
    endtask

    task automatic test_corners();
        drive_sym(0, 128, 1'b0);
        idle(200);
        check_val("n128_idx0_re", cap_re[1][0], 64);
        check_val("n128_idx63_re", cap_re[1][63], 127);
        check_val("n128_idx64_re", cap_re[1][64], 0);
        check_val("n128_idx127_re", cap_re[1][127], 63);
        check_val("n128_first_en_latency", first_cyc[1] - last_in_cyc, 2);
        check_val("n2_idx0_re", cap_re[2][0], 127);
        check_val("n2_idx1_re", cap_re[2][1], 0);
        check_val("n2_last_latency", last_cyc[2] - last_in_cyc, 3);
        check_drained("corners");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_reset();
        test_back_to_back();
        test_gapped();
        test_corners();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_shift_demap.md
# fft_shift_demap

Post-FFT subcarrier demapper for the 128-point PUSCH receive chain. It sits directly downstream of the 128-point bit-reverse reorder stage and takes 128 natural-order FFT bins per symbol. It performs the fftshift and discards the guard bins, emitting only the N_ACT active subcarriers in ascending frequency order to the channel-estimation/equalisation stage. Two 128-entry banks in ping-pong let symbol n+1 be written while symbol n is read out.

## Interface
- WIDTH, 18: bit width of each real/imaginary sample.
- N_ACT, 72: number of active subcarriers; even, 2..128.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- di_re, di_im  in  WIDTH signed  input bin, natural order k=0..127.
- di_en  in  1  input sample valid; every asserted cycle consumes one bin.
- do_re, do_im  out  WIDTH signed  output subcarrier sample; 0 when do_en=0.
- do_en  out  1  output valid.
- do_idx  out  7  active-subcarrier index 0..N_ACT-1; 0 when do_en=0.
- do_last  out  1  high with do_en on index N_ACT-1 only.

## Operation
- Storage: two banks, each 128 x 2·WIDTH, indexed by bin k. Each bank has a full flag. Write-bank pointer wb and read-bank pointer rb are both 0 after reset.
- Write side:
  - 7-bit wr_cnt counts di_en cycles.
  - Each di_en cycle writes bank[wb][wr_cnt] and increments wr_cnt.
  - On wr_cnt==127 with di_en: set full[wb], toggle wb, wr_cnt wraps to 0.
  - di_en may have gaps of any length. Symbol boundaries are defined only by the count of 128.
- Read-side FSM:
  - IDLE: if full[rb], go to READ with rd_cnt=0.
  - READ: each cycle issue read of bin addr(rd_cnt) from bank[rb] and increment rd_cnt.
  - On rd_cnt==N_ACT-1: clear full[rb] and toggle rb in the same cycle.
  - If full of the other bank is already set (or being set this cycle), stay in READ with rd_cnt=0. Otherwise return to IDLE.
- Address mapping, with H=N_ACT/2: addr(i) = 128-H+i for i<H, and i-H for i≥H. Output order is bins 128-H..127, then 0..H-1, with DC included.
- Output register: memory read is synchronous. do_re/do_im/do_en/do_idx/do_last are registered one cycle after the read is issued. do_idx equals rd_cnt delayed by one cycle.
- No backpressure. The reader drains N_ACT ≤ 128 entries before the writer can fill the other bank, so overflow cannot occur; no overflow logic is required.
- Clearing full[rb] and setting full for the same bank in the same cycle cannot coincide. If a write targets the bank whose read completes that cycle, the release takes effect first and the write is permitted.
- Arithmetic: samples pass through unmodified; no scaling or rounding.

## Timing
- Reset values:
  - Outputs: do_re=0, do_im=0, do_en=0, do_idx=0, do_last=0.
  - Internal: wr_cnt=0, rd_cnt=0, wb=0, rb=0, both full=0, FSM=IDLE.
- Reset mid-operation: any partial or stored symbol is discarded. The first di_en after rst deasserts is bin 0 of a new symbol.
- Latency: if the 128th input bin is written at cycle T:
  - full is visible at T+1 and the first read is issued at T+1.
  - The first do_en is at T+2.
  - do_last is at T+1+N_ACT.
- Output burst: N_ACT consecutive do_en cycles per symbol with no gaps.
- Back-to-back full symbols: the second burst starts at the cycle right after the first do_last. There is no idle cycle between bursts.
- With continuous di_en, output duty is N_ACT/128: 72 valid cycles, then 56 idle cycles, per symbol.

## Test plan
- Basic mapping, N_ACT=72: drive 128 continuous bins with re=k, im=-k.
  - Expect 72 outputs: idx0 re=92 im=-92; idx35 re=127; idx36 re=0; idx71 re=35 with do_last=1.
  - First do_en exactly 2 cycles after the 128th di_en.
- Reset values and mid-symbol reset:
  - Check all outputs are 0 during rst.
  - Assert rst after 60 bins, then send a full symbol with re=k+1000.
  - Expect exactly 72 outputs, starting with re=1092, and no residue from the aborted symbol.
- Continuous stream: 4 back-to-back symbols, symbol s carrying re=256·s+k.
  - Expect 4 bursts of 72 in order and bank ping-pong correct.
  - Expect 56 idle cycles between do_last and the next do_en.
- Gapped input: the same symbol with di_en toggling 1-0-0 pseudo-randomly.
  - Expect output identical to the basic test; latency measured from the 128th di_en is still 2 cycles.
- Parameter corners:
  - N_ACT=128: output is the full fftshift, idx0 re=64, idx63 re=127, idx64 re=0, idx127 re=63.
  - Back-to-back symbols, checked as a boundary condition: 128 outputs per symbol, with the next burst starting immediately after do_last.
  - N_ACT=2: outputs re=127 then re=0.
